// File: rtl/input_debouncer_if.sv
// Pad-side bundle for input_debouncer: raw pad bits in, conditioned levels,
// edge pulses and the lane-0 rising-edge counter out.
interface input_debouncer_if #(
  parameter int unsigned LANES = 8
);
  logic [LANES-1:0] din;
  logic [LANES-1:0] dout;
  logic [LANES-1:0] rise;
  logic [LANES-1:0] fall;
  logic [7:0]       count;

  modport master (
    output din,
    input  dout,
    input  rise,
    input  fall,
    input  count
  );

  modport slave (
    input  din,
    output dout,
    output rise,
    output fall,
    output count
  );
endinterface

// File: rtl/input_debouncer.sv
// Per-lane two-flop synchroniser plus stability-counter debouncer with
// registered rise/fall pulses and a wrapping count of lane-0 rising edges.
module input_debouncer #(
  parameter int unsigned LANES  = 8,
  parameter int unsigned STABLE = 4
) (
  input logic               clk,
  input logic               rst,
  input_debouncer_if.slave  bus
);

  typedef enum logic {StStable0, StStable1} state_e;

  localparam logic [7:0] CntLast = 8'(STABLE - 1);

  logic [LANES-1:0] s0_q, s1_q;
  logic [LANES-1:0] rise_q, rise_d;
  logic [LANES-1:0] fall_q, fall_d;
  state_e           state_q [LANES];
  state_e           state_d [LANES];
  logic [7:0]       cnt_q   [LANES];
  logic [7:0]       cnt_d   [LANES];
  logic [7:0]       count_q, count_d;

  // Each lane's debounced level is its FSM state; a candidate change is
  // abandoned (counter cleared) as soon as the sample matches the state again.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < LANES; i++) begin
      unique case (state_q[i])
        StStable0: begin
          if (!s1_q[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CntLast) begin
            state_d[i] = StStable1;
            cnt_d[i]   = '0;
            rise_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 8'd1;
          end
        end
        StStable1: begin
          if (s1_q[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CntLast) begin
            state_d[i] = StStable0;
            cnt_d[i]   = '0;
            fall_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 8'd1;
          end
        end
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    if (rise_d[0]) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q    <= '0;
      s1_q    <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < LANES; i++) begin
        state_q[i] <= StStable0;
        cnt_q[i]   <= '0;
      end
    end else begin
      s0_q    <= bus.din;
      s1_q    <= s0_q;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      count_q <= count_d;
      for (int i = 0; i < LANES; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    bus.dout = '0;
    for (int i = 0; i < LANES; i++) begin
      bus.dout[i] = (state_q[i] == StStable1);
    end
  end

  assign bus.rise  = rise_q;
  assign bus.fall  = fall_q;
  assign bus.count = count_q;

endmodule
